// File: rtl/gaussian_core_pipe.sv
// gaussian_core_pipe: KSIZE x KSIZE binomial blur with round-half-up; GAUSS_BYPASS_EN adds a centre-pixel bypass.
// Latency clog2(KSIZE^2)+2 cycles; a single global enable freezes every stage while out_valid && !out_ready.
module gaussian_core_pipe #(
  parameter int KSIZE = 7,
  parameter int PIX_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [KSIZE*KSIZE*PIX_W-1:0] in_pixels,
`ifdef GAUSS_BYPASS_EN
  input  logic                         bypass,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PIX_W-1:0]             out_pixel
);
  localparam int NPIX     = KSIZE * KSIZE;
  localparam int SHIFT    = 2 * (KSIZE - 1);
  localparam int ACC_W    = PIX_W + SHIFT;
  localparam int ADD_LVLS = $clog2(NPIX);
  localparam int CTR      = NPIX / 2;
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int lvl_cnt(input int l);
    int n;
    n = NPIX;
    for (int i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  if (KSIZE != 3 && KSIZE != 5 && KSIZE != 7) begin : g_bad_ksize
    $error("gaussian_core_pipe: KSIZE must be 3, 5 or 7");
  end

  logic en;
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign en       = in_ready;

  // tree[0] holds the weighted products; tree[l] holds adder level l, tree[ADD_LVLS][0] is the full sum.
  logic [ACC_W-1:0]  tree [ADD_LVLS+1][NPIX];
  logic [ADD_LVLS:0] vld;

  for (genvar l = 0; l <= ADD_LVLS; l++) begin : g_lvl
    for (genvar i = 0; i < NPIX; i++) begin : g_e
      if (l == 0) begin : g_mul
        localparam logic [ACC_W-1:0] WGT =
          ACC_W'(binom(KSIZE - 1, i / KSIZE) * binom(KSIZE - 1, i % KSIZE));
        always_ff @(posedge clk) begin
          if (!rst_n)  tree[l][i] <= '0;
          else if (en) tree[l][i] <= ACC_W'(in_pixels[i*PIX_W +: PIX_W]) * WGT;
        end
      end else if (2 * i + 1 < lvl_cnt(l - 1)) begin : g_add
        always_ff @(posedge clk) begin
          if (!rst_n)  tree[l][i] <= '0;
          else if (en) tree[l][i] <= tree[l-1][2*i] + tree[l-1][2*i+1];
        end
      end else if (i < lvl_cnt(l)) begin : g_pass
        // Odd element left over at this level rides through unchanged.
        always_ff @(posedge clk) begin
          if (!rst_n)  tree[l][i] <= '0;
          else if (en) tree[l][i] <= tree[l-1][2*i];
        end
      end else begin : g_zero
        always_ff @(posedge clk) begin
          tree[l][i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  vld <= '0;
    else if (en) vld <= {vld[ADD_LVLS-1:0], in_valid};
  end

  // Sum never exceeds (2^PIX_W-1)*2^SHIFT, so the rounded shift always fits PIX_W bits.
  logic [PIX_W-1:0] filt;
  logic [PIX_W-1:0] res;
  assign filt = PIX_W'((tree[ADD_LVLS][0] + HALF) >> SHIFT);

`ifdef GAUSS_BYPASS_EN
  logic [ADD_LVLS:0] byp;
  logic [PIX_W-1:0]  ctr [ADD_LVLS+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp <= '0;
      for (int l = 0; l <= ADD_LVLS; l++) ctr[l] <= '0;
    end else if (en) begin
      byp    <= {byp[ADD_LVLS-1:0], bypass};
      ctr[0] <= in_pixels[CTR*PIX_W +: PIX_W];
      for (int l = 1; l <= ADD_LVLS; l++) ctr[l] <= ctr[l-1];
    end
  end

  assign res = byp[ADD_LVLS] ? ctr[ADD_LVLS] : filt;
`else
  assign res = filt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else if (en) begin
      out_valid <= vld[ADD_LVLS];
      out_pixel <= res;
    end
  end

endmodule

// File: tb/tb_gaussian_core_pipe.sv
// Bench for gaussian_core_pipe: K=7 and K=3 instances, directed scenarios plus randomized scoreboard traffic.
module tb_gaussian_core_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic         v7 = 1'b0, ordy7 = 1'b0, byp7 = 1'b0;
  logic         ir7, ov7;
  logic [391:0] pix7 = '0;
  logic [7:0]   op7;

  logic         v3 = 1'b0, ordy3 = 1'b0, byp3 = 1'b0;
  logic         ir3, ov3;
  logic [71:0]  pix3 = '0;
  logic [7:0]   op3;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp7[$];
  logic [7:0] exp3[$];
  logic [7:0] e7, e3, hold7, hold3;
  bit         st7 = 1'b0, st3 = 1'b0;

  always #5 clk = ~clk;

  gaussian_core_pipe #(.KSIZE(7), .PIX_W(8)) u7 (
    .clk(clk), .rst_n(rst_n), .in_valid(v7), .in_ready(ir7), .in_pixels(pix7),
`ifdef GAUSS_BYPASS_EN
    .bypass(byp7),
`endif
    .out_valid(ov7), .out_ready(ordy7), .out_pixel(op7));

  gaussian_core_pipe #(.KSIZE(3), .PIX_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3), .in_pixels(pix3),
`ifdef GAUSS_BYPASS_EN
    .bypass(byp3),
`endif
    .out_valid(ov3), .out_ready(ordy3), .out_pixel(op3));

  function automatic longint fact(input int n);
    longint f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Reference: binomial coefficients from factorials, exact integer division for the rounding.
  function automatic logic [7:0] model(input int ks, input logic [391:0] pix, input logic byp);
    longint acc = 0;
    longint wr, wc, half, den;
    int     n = ks - 1;
    if (byp) return pix[(ks*ks/2)*8 +: 8];
    for (int r = 0; r < ks; r++) begin
      wr = fact(n) / (fact(r) * fact(n - r));
      for (int c = 0; c < ks; c++) begin
        wc  = fact(n) / (fact(c) * fact(n - c));
        acc = acc + wr * wc * longint'(pix[(r*ks+c)*8 +: 8]);
      end
    end
    den  = longint'(1) << (2 * n);
    half = den / 2;
    return 8'((acc + half) / den);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp7.delete();
      exp3.delete();
      st7 = 1'b0;
      st3 = 1'b0;
    end else begin
      checks++;
      if (ir7 !== (!ov7 || ordy7)) begin
        failures++;
        $display("FAIL k7_in_ready got=%b want=%b", ir7, (!ov7 || ordy7));
      end
      if (st7) begin
        checks++;
        if (ov7 !== 1'b1 || op7 !== hold7) begin
          failures++;
          $display("FAIL k7_stall_hold got valid=%b pix=%h want valid=1 pix=%h", ov7, op7, hold7);
        end
      end
      if (ov7 === 1'b1 && ordy7) begin
        checks++;
        if (exp7.size() == 0) begin
          failures++;
          $display("FAIL k7_unexpected_out got=%h want=none", op7);
        end else begin
          e7 = exp7.pop_front();
          if (op7 !== e7) begin
            failures++;
            $display("FAIL k7_scoreboard got=%h want=%h", op7, e7);
          end
        end
      end
      if (v7 && ir7 === 1'b1) exp7.push_back(model(7, pix7, byp7));
      st7   = (ov7 === 1'b1) && !ordy7;
      hold7 = op7;

      checks++;
      if (ir3 !== (!ov3 || ordy3)) begin
        failures++;
        $display("FAIL k3_in_ready got=%b want=%b", ir3, (!ov3 || ordy3));
      end
      if (st3) begin
        checks++;
        if (ov3 !== 1'b1 || op3 !== hold3) begin
          failures++;
          $display("FAIL k3_stall_hold got valid=%b pix=%h want valid=1 pix=%h", ov3, op3, hold3);
        end
      end
      if (ov3 === 1'b1 && ordy3) begin
        checks++;
        if (exp3.size() == 0) begin
          failures++;
          $display("FAIL k3_unexpected_out got=%h want=none", op3);
        end else begin
          e3 = exp3.pop_front();
          if (op3 !== e3) begin
            failures++;
            $display("FAIL k3_scoreboard got=%h want=%h", op3, e3);
          end
        end
      end
      if (v3 && ir3 === 1'b1) exp3.push_back(model(3, {320'b0, pix3}, byp3));
      st3   = (ov3 === 1'b1) && !ordy3;
      hold3 = op3;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pix7();
    for (int p = 0; p < 49; p++) pix7[p*8 +: 8] = 8'($urandom);
  endtask

  task automatic rand_pix3();
    for (int p = 0; p < 9; p++) pix3[p*8 +: 8] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v7 = 1'b0; v3 = 1'b0; ordy7 = 1'b1; ordy3 = 1'b1;
    repeat (3) tick();
    checks++; if (ov7 !== 1'b0) begin failures++; $display("FAIL reset_ov7 got=%b want=0", ov7); end
    checks++; if (op7 !== 8'h00) begin failures++; $display("FAIL reset_op7 got=%h want=00", op7); end
    checks++; if (ir7 !== 1'b0) begin failures++; $display("FAIL reset_ir7 got=%b want=0", ir7); end
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL reset_ov3 got=%b want=0", ov3); end
    checks++; if (ir3 !== 1'b0) begin failures++; $display("FAIL reset_ir3 got=%b want=0", ir3); end
    rst_n = 1'b1;
    tick();
    checks++; if (ir7 !== 1'b1) begin failures++; $display("FAIL release_ir7 got=%b want=1", ir7); end
    checks++; if (ir3 !== 1'b1) begin failures++; $display("FAIL release_ir3 got=%b want=1", ir3); end
    checks++; if (ov7 !== 1'b0) begin failures++; $display("FAIL release_ov7 got=%b want=0", ov7); end
  endtask

  task automatic test_latency_all_ff();
    pix7 = {49{8'hFF}};
    v7   = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) v7 = 1'b0;
      checks++;
      if (ov7 !== (e == 8)) begin
        failures++;
        $display("FAIL lat_ff_valid edge=%0d got=%b want=%b", e, ov7, (e == 8));
      end
    end
    checks++; if (op7 !== 8'hFF) begin failures++; $display("FAIL lat_ff_pixel got=%h want=ff", op7); end
    tick();
  endtask

  task automatic test_impulse_pair();
    int n = 0;
    pix7 = {49{8'h01}};
    v7   = 1'b1;
    tick();
    pix7 = '0;
    pix7[24*8 +: 8] = 8'hFF;
    tick();
    v7 = 1'b0;
    while (ov7 !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 6) begin failures++; $display("FAIL pair_latency got=%0d want=6", n); end
    checks++; if (op7 !== 8'h01) begin failures++; $display("FAIL pair_first got=%h want=01", op7); end
    tick();
    checks++;
    if (ov7 !== 1'b1 || op7 !== 8'h19) begin
      failures++;
      $display("FAIL pair_second got valid=%b pix=%h want valid=1 pix=19", ov7, op7);
    end
    tick();
  endtask

  task automatic test_k3();
    logic [7:0] want;
    for (int t = 0; t < 2; t++) begin
      pix3 = '0;
      pix3[(t == 0 ? 4 : 0)*8 +: 8] = 8'hFF;
      want = (t == 0) ? 8'h40 : 8'h10;
      v3   = 1'b1;
      for (int e = 1; e <= 6; e++) begin
        tick();
        if (e == 1) v3 = 1'b0;
        checks++;
        if (ov3 !== (e == 6)) begin
          failures++;
          $display("FAIL k3_latency pat=%0d edge=%0d got=%b want=%b", t, e, ov3, (e == 6));
        end
      end
      checks++;
      if (op3 !== want) begin failures++; $display("FAIL k3_pixel pat=%0d got=%h want=%h", t, op3, want); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    ordy7 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pix7 = {49{8'(k)}};
      v7   = 1'b1;
      tick();
    end
    v7 = 1'b0;
    while (ov7 !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 5) begin failures++; $display("FAIL bp_latency got=%0d want=5", n); end
    ordy7 = 1'b0;
    for (int h = 0; h <= 4; h++) begin
      #1;
      checks++;
      if (ir7 !== 1'b0 || ov7 !== 1'b1 || op7 !== 8'h01) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got ir=%b ov=%b pix=%h want ir=0 ov=1 pix=01", h, ir7, ov7, op7);
      end
      if (h < 4) tick();
    end
    ordy7 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (ov7 !== 1'b1 || op7 !== 8'(k)) begin
        failures++;
        $display("FAIL bp_order idx=%0d got ov=%b pix=%h want ov=1 pix=%h", k, ov7, op7, 8'(k));
      end
      tick();
    end
    checks++; if (ov7 !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", ov7); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] want;
    bit         seen = 1'b0;
    ordy7 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_pix7();
      v7 = 1'b1;
      tick();
    end
    v7    = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (ov7 !== 1'b0) begin failures++; $display("FAIL rstmid_ov got=%b want=0", ov7); end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ov7 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rstmid_leak got=1 want=0"); end
    rand_pix7();
    want = model(7, pix7, 1'b0);
    v7   = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) v7 = 1'b0;
      checks++;
      if (ov7 !== (e == 8)) begin
        failures++;
        $display("FAIL rstmid_latency edge=%0d got=%b want=%b", e, ov7, (e == 8));
      end
    end
    checks++; if (op7 !== want) begin failures++; $display("FAIL rstmid_pixel got=%h want=%h", op7, want); end
    tick();
  endtask

`ifdef GAUSS_BYPASS_EN
  task automatic test_bypass();
    int n = 0;
    pix7 = '0;
    pix7[24*8 +: 8] = 8'hFF;
    byp7 = 1'b1;
    v7   = 1'b1;
    ordy7 = 1'b1;
    tick();
    byp7 = 1'b0;
    tick();
    v7 = 1'b0;
    while (ov7 !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (op7 !== 8'hFF) begin failures++; $display("FAIL bypass_first got=%h want=ff", op7); end
    tick();
    checks++;
    if (ov7 !== 1'b1 || op7 !== 8'h19) begin
      failures++;
      $display("FAIL bypass_second got ov=%b pix=%h want ov=1 pix=19", ov7, op7);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      v7    = ($urandom_range(0, 3) != 0);
      ordy7 = ($urandom_range(0, 3) != 0);
      v3    = ($urandom_range(0, 3) != 0);
      ordy3 = ($urandom_range(0, 3) != 0);
      rand_pix7();
      rand_pix3();
      if (c % 50 == 7) pix7 = '0;
      if (c % 50 == 9) pix3 = {9{8'hFF}};
`ifdef GAUSS_BYPASS_EN
      byp7 = 1'($urandom_range(0, 1));
      byp3 = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    v7 = 1'b0; v3 = 1'b0; ordy7 = 1'b1; ordy3 = 1'b1; byp7 = 1'b0; byp3 = 1'b0;
    repeat (15) tick();
    checks++; if (exp7.size() != 0) begin failures++; $display("FAIL rand_drain7 left=%0d want=0", exp7.size()); end
    checks++; if (exp3.size() != 0) begin failures++; $display("FAIL rand_drain3 left=%0d want=0", exp3.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_latency_all_ff();
    test_impulse_pair();
    test_k3();
    test_backpressure();
    test_reset_mid();
`ifdef GAUSS_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
